// File: rtl/gru_frame_sequencer.sv
// Byte-stream front end for the combinational GRU cell: assembles operand frames,
// applies them, waits CELL_LAT cycles and returns h_out. Option: GRU_RECUR_EN chains h_out into h_in.
module gru_frame_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int CELL_LAT   = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] cell_X,
    output logic [DATA_WIDTH-1:0] cell_h_in,
    output logic [DATA_WIDTH-1:0] cell_Wz,
    output logic [DATA_WIDTH-1:0] cell_Wr,
    output logic [DATA_WIDTH-1:0] cell_Wh,
    output logic [DATA_WIDTH-1:0] cell_Uz,
    output logic [DATA_WIDTH-1:0] cell_Ur,
    output logic [DATA_WIDTH-1:0] cell_Uh,
    output logic [DATA_WIDTH-1:0] cell_bz,
    output logic [DATA_WIDTH-1:0] cell_br,
    output logic [DATA_WIDTH-1:0] cell_bh,
    input  logic [DATA_WIDTH-1:0] cell_h_out,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  frame_count,
    output logic                  busy
);
    // state | meaning
    // LOAD  | accepting frame bytes into the shadow bank
    // APPLY | operands on the cell, settle counter running
    // SEND  | result held on m_data until downstream takes it
    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_APPLY = 2'd1;
    localparam logic [1:0] ST_SEND  = 2'd2;

`ifdef GRU_RECUR_EN
    localparam int FRAME_LEN = 10;
`else
    localparam int FRAME_LEN = 11;
`endif
    localparam int IDX_W  = 4;
    localparam int N_CELL = 11;
    // Stream position of cell operand k (k >= 2) is k - SKIP.
    localparam int SKIP   = N_CELL - FRAME_LEN;

    logic [1:0]            r_state;
    logic [IDX_W-1:0]      r_idx;
    logic [3:0]            r_cnt;
    logic [DATA_WIDTH-1:0] r_shadow [FRAME_LEN];
    logic [DATA_WIDTH-1:0] r_cell   [N_CELL];
    logic [DATA_WIDTH-1:0] r_m_data;
    logic                  r_m_valid;
    logic [CNT_WIDTH-1:0]  r_frame_count;
    logic [DATA_WIDTH-1:0] r_h_rec;

    logic                  w_accept;
    logic                  w_last;
    logic                  w_hs;
    logic [DATA_WIDTH-1:0] w_frame [FRAME_LEN];

    assign w_accept = s_valid && (r_state == ST_LOAD);
    assign w_last   = (r_idx == IDX_W'(FRAME_LEN - 1));
    assign w_hs     = r_m_valid && m_ready;

    // Shadow bank with the byte being accepted this cycle merged in.
    always_comb begin
        for (int i = 0; i < FRAME_LEN; i++) begin
            w_frame[i] = (w_accept && (r_idx == IDX_W'(i))) ? s_data : r_shadow[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_LOAD;
            r_idx         <= '0;
            r_cnt         <= '0;
            r_m_data      <= '0;
            r_m_valid     <= 1'b0;
            r_frame_count <= '0;
            r_h_rec       <= '0;
            for (int i = 0; i < FRAME_LEN; i++) r_shadow[i] <= '0;
            for (int i = 0; i < N_CELL; i++)    r_cell[i]   <= '0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_accept) begin
                        r_shadow <= w_frame;
                        if (w_last) begin
                            r_idx     <= '0;
                            r_cnt     <= 4'(CELL_LAT);
                            r_state   <= ST_APPLY;
                            r_cell[0] <= w_frame[0];
`ifdef GRU_RECUR_EN
                            r_cell[1] <= r_h_rec;
`else
                            r_cell[1] <= w_frame[1];
`endif
                            for (int k = 2; k < N_CELL; k++) r_cell[k] <= w_frame[k - SKIP];
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                ST_APPLY: begin
                    if (r_cnt == 4'd1) begin
                        r_m_data  <= cell_h_out;
                        r_m_valid <= 1'b1;
                        r_state   <= ST_SEND;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_SEND: begin
                    if (w_hs) begin
                        r_m_valid     <= 1'b0;
                        r_frame_count <= r_frame_count + 1'b1;
                        r_h_rec       <= r_m_data;
                        r_state       <= ST_LOAD;
                    end
                end
                default: r_state <= ST_LOAD;
            endcase
        end
    end

    assign s_ready     = (r_state == ST_LOAD);
    assign busy        = (r_state != ST_LOAD) || (r_idx != '0);
    assign m_data      = r_m_data;
    assign m_valid     = r_m_valid;
    assign frame_count = r_frame_count;

    assign cell_X    = r_cell[0];
    assign cell_h_in = r_cell[1];
    assign cell_Wz   = r_cell[2];
    assign cell_Wr   = r_cell[3];
    assign cell_Wh   = r_cell[4];
    assign cell_Uz   = r_cell[5];
    assign cell_Ur   = r_cell[6];
    assign cell_Uh   = r_cell[7];
    assign cell_bz   = r_cell[8];
    assign cell_br   = r_cell[9];
    assign cell_bh   = r_cell[10];
endmodule
